// File: rtl/mux_8x1_rr.sv
// mux_8x1_rr
// Eight-channel round-robin collector. Merges eight valid/ready input streams
// onto one registered output stream, tagging each word with its source lane.
//
// Ports:
//   clk_i    - single clock, rising edge
//   rst_i    - synchronous, active-high reset
//   valid_i  - per-channel valid, bit k qualifies data_i[k]
//   data_i   - per-channel data words
//   ready_o  - per-channel ready, one-hot or zero
//   valid_o  - output word valid
//   data_o   - output word
//   sel_o    - source channel index of data_o
//   ready_i  - downstream ready
module mux_8x1_rr #(
  parameter int N = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       valid_i,
  input  logic [7:0][N:0]  data_i,
  output logic [7:0]       ready_o,
  output logic             valid_o,
  output logic [N:0]       data_o,
  output logic [2:0]       sel_o,
  input  logic             ready_i
);

  logic       valid_q, valid_d;
  logic [N:0] data_q,  data_d;
  logic [2:0] sel_q,   sel_d;
  logic [2:0] ptr_q,   ptr_d;

  logic       load_en_s;
  logic       found_s;
  logic [2:0] win_s;
  logic [2:0] idx_s;
  logic       grant_s;

  // Output register can accept a new word when empty or draining this cycle.
  assign load_en_s = ~valid_q | ready_i;

  // Round-robin search: scan from the highest offset down so the lowest
  // offset from ptr_q (the nearest valid channel) is the last one written.
  always_comb begin
    found_s = 1'b0;
    win_s   = 3'd0;
    idx_s   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx_s   = ptr_q + 3'(i);
      win_s   = valid_i[idx_s] ? idx_s : win_s;
      found_s = found_s | valid_i[idx_s];
    end
  end

  // Reset masks the grant so no channel is consumed while rst_i is high.
  assign grant_s = found_s & load_en_s & ~rst_i;

  // One-hot ready towards the winning channel only.
  always_comb begin
    ready_o = 8'd0;
    if (grant_s) begin
      ready_o = 8'd1 << win_s;
    end else begin
      ready_o = 8'd0;
    end
  end

  // Next-state: load on a transfer, empty on an idle load slot, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (grant_s) begin
      valid_d = 1'b1;
      data_d  = data_i[win_s];
      sel_d   = win_s;
      ptr_d   = win_s + 3'd1;
    end else if (load_en_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset; reset drops any held word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_mux_8x1_rr.sv
// Testbench for mux_8x1_rr: behavioural sources feed the DUT, a reference model
// predicts ready_o and the output register, and a scoreboard queue holds the
// words expected on the output, in order.
module tb_mux_8x1_rr;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [7:0]      valid_i;
  logic [7:0][3:0] data_i;
  logic [7:0]      ready_o;
  logic            valid_o;
  logic [3:0]      data_o;
  logic [2:0]      sel_o;
  logic            ready_i;

  mux_8x1_rr #(.N(3)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .sel_o   (sel_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Sources: words still to send per channel, and the word each presents.
  int         src_cnt [8];
  logic [3:0] src_data [8];

  // Reference model state.
  logic       m_valid = 1'b0;
  logic [3:0] m_data  = 4'd0;
  logic [2:0] m_sel   = 3'd0;
  logic [2:0] m_ptr   = 3'd0;
  logic [6:0] sb_q [$];
  logic [7:0] obs_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_sources();
    for (int k = 0; k < 8; k++) begin
      valid_i[k] = (src_cnt[k] != 0);
      data_i[k]  = src_data[k];
    end
  endtask

  // One clock cycle: check the settled DUT against the model at the falling
  // edge, advance model and sources, then present the next inputs.
  task automatic cycle();
    logic [7:0] exp_rdy;
    logic [2:0] w;
    logic       found;
    logic [6:0] front;
    @(negedge clk_i);
    #1;
    exp_rdy = 8'd0;
    w       = 3'd0;
    found   = 1'b0;
    if (!rst_i && (!m_valid || ready_i)) begin
      for (int i = 0; i < 8; i++) begin
        if (!found && valid_i[3'(m_ptr + 3'(i))]) begin
          found = 1'b1;
          w     = 3'(m_ptr + 3'(i));
        end
      end
      if (found) exp_rdy = 8'd1 << w;
    end
    obs_ready = ready_o;
    check_val("ready_o", {24'd0, ready_o}, {24'd0, exp_rdy});
    check_val("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
    check_val("data_o",  {28'd0, data_o},  {28'd0, m_data});
    check_val("sel_o",   {29'd0, sel_o},   {29'd0, m_sel});
    if (!rst_i && valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_out", {25'd0, sel_o, data_o}, 32'hFFFF_FFFF);
      end else begin
        front = sb_q.pop_front();
        check_val("sb_word", {25'd0, sel_o, data_o}, {25'd0, front});
      end
    end
    if (rst_i) begin
      m_valid = 1'b0; m_data = 4'd0; m_sel = 3'd0; m_ptr = 3'd0;
      sb_q.delete();
    end else if (found) begin
      sb_q.push_back({w, data_i[w]});
      m_valid = 1'b1; m_data = data_i[w]; m_sel = w; m_ptr = w + 3'd1;
    end else if (!m_valid || ready_i) begin
      m_valid = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      if (valid_i[k] && ready_o[k] && src_cnt[k] > 0) src_cnt[k]--;
    end
    @(posedge clk_i);
    #1;
    drive_sources();
  endtask

  initial begin
    rst_i   = 1'b1;
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src_cnt[k]  = 2;
      src_data[k] = 4'(k + 1);
    end
    drive_sources();
    @(posedge clk_i);
    #1;

    // Reset held with all channels valid: nothing granted, outputs zero.
    cycle();
    cycle();
    rst_i = 1'b0;

    // Full round-robin, 16 cycles, first grant to channel 0.
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (i == 0) check_val("first_grant", {24'd0, obs_ready}, 32'h01);
      check_val("rr_valid", {31'd0, valid_o}, 32'd1);
      check_val("rr_sel",   {29'd0, sel_o},   32'(i % 8));
      check_val("rr_data",  {28'd0, data_o},  32'((i % 8) + 1));
    end
    cycle();

    // Single channel 5.
    src_cnt[5] = 1; src_data[5] = 4'hA;
    drive_sources();
    cycle();
    check_val("single_ready", {24'd0, obs_ready}, 32'h20);
    check_val("single_valid", {31'd0, valid_o}, 32'd1);
    check_val("single_data",  {28'd0, data_o},  32'hA);
    check_val("single_sel",   {29'd0, sel_o},   32'd5);
    cycle();
    check_val("drop_valid", {31'd0, valid_o}, 32'd0);
    check_val("drop_data",  {28'd0, data_o},  32'hA);

    // Wrap and skip from ptr 6: channels 1 and 6.
    src_cnt[1] = 2; src_data[1] = 4'h3;
    src_cnt[6] = 2; src_data[6] = 4'hC;
    drive_sources();
    cycle();
    check_val("wrap_g0", {24'd0, obs_ready}, 32'h40);
    cycle();
    check_val("wrap_g1", {24'd0, obs_ready}, 32'h02);
    cycle();
    check_val("wrap_g2", {24'd0, obs_ready}, 32'h40);
    cycle();
    check_val("wrap_g3", {24'd0, obs_ready}, 32'h02);
    cycle();

    // Backpressure from ptr 2: channels 0, 3, 5.
    src_cnt[0] = 1; src_data[0] = 4'h7;
    src_cnt[3] = 1; src_data[3] = 4'h9;
    src_cnt[5] = 1; src_data[5] = 4'hE;
    ready_i = 1'b0;
    drive_sources();
    cycle();
    check_val("bp_load", {24'd0, obs_ready}, 32'h08);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("bp_ready", {24'd0, obs_ready}, 32'h00);
      check_val("bp_sel",   {29'd0, sel_o},  32'd3);
      check_val("bp_data",  {28'd0, data_o}, 32'h9);
    end
    ready_i = 1'b1;
    cycle();
    check_val("bp_fill_ready", {24'd0, obs_ready}, 32'h20);
    check_val("bp_fill_sel",   {29'd0, sel_o},     32'd5);
    cycle();
    check_val("bp_fill2_sel",  {29'd0, sel_o},     32'd0);
    cycle();
    cycle();
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    // Mid-operation reset while a word is held under backpressure.
    src_cnt[4] = 1; src_data[4] = 4'h5;
    ready_i = 1'b0;
    drive_sources();
    cycle();
    cycle();
    check_val("mr_held_sel", {29'd0, sel_o}, 32'd4);
    src_cnt[3] = 1; src_data[3] = 4'h2;
    src_cnt[7] = 1; src_data[7] = 4'h6;
    drive_sources();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    check_val("mr_valid", {31'd0, valid_o}, 32'd0);
    check_val("mr_sel",   {29'd0, sel_o},   32'd0);
    ready_i = 1'b1;
    cycle();
    check_val("mr_restart", {24'd0, obs_ready}, 32'h08);
    cycle();
    cycle();
    cycle();
    check_val("mr_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
